// File: rtl/pipeline_dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage of the 5-stage pipeline.
// Optional DMEM_MMIO_EN adds a memory-mapped output register (mmio_out) at 32'hFFFF_FF00.
module pipeline_dmem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_stall
`ifdef DMEM_MMIO_EN
    ,
    output logic [31:0] mmio_out
`endif
);

    localparam int unsigned DEPTH     = 1 << ADDR_W;
    localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);
    localparam logic [31:0] MMIO_ADDR = 32'hFFFF_FF00;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q,   cnt_d;
    logic                we_q,    we_d;
    logic                mis_q,   mis_d;
    logic [ADDR_W-1:0]   idx_q,   idx_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q,    be_d;
    logic                mmio_hit_q, mmio_hit_d;

    logic [31:0]         mem [DEPTH];
    logic                commit;
    logic                mem_we;
    logic                unused_addr;

    // Bits above the word index only matter for the MMIO decode.
    assign unused_addr = ^req_addr[31:ADDR_W+2];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            mis_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            mmio_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            mis_q      <= mis_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            mmio_hit_q <= mmio_hit_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        mis_d      = mis_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        mmio_hit_d = mmio_hit_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_stall  = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                mem_stall = req_valid;
                if (req_valid) begin
                    we_d       = req_we;
                    mis_d      = |req_addr[1:0];
                    idx_d      = req_addr[ADDR_W+1:2];
                    wdata_d    = req_wdata;
                    be_d       = req_be;
`ifdef DMEM_MMIO_EN
                    mmio_hit_d = (req_addr == MMIO_ADDR);
`else
                    mmio_hit_d = 1'b0;
`endif
                    cnt_d      = CNT_INIT;
                    state_d    = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The write lands on the edge leaving RESP; an async reset pulls the
    // FSM out of RESP first, so an aborted store never commits.
    assign commit = (state_q == S_RESP) && we_q && !mis_q;
    assign mem_we = commit && !mmio_hit_q;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_q;
    logic        mmio_we;

    assign mmio_we  = commit && mmio_hit_q;
    assign mmio_out = mmio_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mmio_q <= '0;
        end else if (mmio_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mmio_q[8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end
`endif

    always_comb begin
        resp_rdata = '0;
        resp_err   = 1'b0;
        if (state_q == S_RESP) begin
            resp_err = mis_q;
            if (!we_q && !mis_q) begin
`ifdef DMEM_MMIO_EN
                resp_rdata = mmio_hit_q ? mmio_q : mem[idx_q];
`else
                resp_rdata = mem[idx_q];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipeline_dmem_responder.sv
// Directed bench for pipeline_dmem_responder: LATENCY=3 main instance plus a LATENCY=1 twin.
module tb_pipeline_dmem_responder;

    localparam int unsigned LAT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        rst1;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        req_ready,  resp_valid,  resp_err,  mem_stall;
    logic [31:0] resp_rdata;
    logic        req1_ready, resp1_valid, resp1_err, mem1_stall;
    logic [31:0] resp1_rdata;
`ifdef DMEM_MMIO_EN
    logic [31:0] mmio_out, mmio1_out;
`endif

    always #5 clock = ~clock;

    pipeline_dmem_responder #(.ADDR_W(8), .LATENCY(LAT)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_stall  (mem_stall)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_out   (mmio_out)
`endif
    );

    pipeline_dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_dut1 (
        .clock      (clock),
        .reset      (rst1),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_ready  (req1_ready),
        .resp_valid (resp1_valid),
        .resp_rdata (resp1_rdata),
        .resp_err   (resp1_err),
        .mem_stall  (mem1_stall)
`ifdef DMEM_MMIO_EN
        ,
        .mmio_out   (mmio1_out)
`endif
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t        vecs[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // One complete transaction on both instances; inputs are scrambled while busy.
    task automatic run_txn(input string tag, input vec_t v, input bit chk1);
        int unsigned lat;
        @(negedge clock);
        check({tag, " ready_idle"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_be    = v.be;
        #1;
        check({tag, " stall_req"}, mem_stall, 1);
        @(negedge clock);
        req_valid = 1'b0;
        req_we    = ~v.we;
        req_addr  = v.addr ^ 32'h0000_0014;
        req_wdata = ~v.wdata;
        req_be    = ~v.be;
        if (chk1) begin
            check({tag, " lat1_valid"}, resp1_valid, 1);
            check({tag, " lat1_rdata"}, resp1_rdata, v.exp_rdata);
            check({tag, " lat1_err"}, resp1_err, v.exp_err);
        end
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 20) begin
            check({tag, " busy_stall"}, mem_stall, 1);
            check({tag, " busy_ready"}, req_ready, 0);
            @(negedge clock);
            lat++;
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " resp_stall"}, mem_stall, 0);
        check({tag, " rdata"}, resp_rdata, v.exp_rdata);
        check({tag, " err"}, resp_err, v.exp_err);
        @(negedge clock);
        check({tag, " pulse_end"}, resp_valid, 0);
    endtask

    initial begin
        bit saw_resp;

        vecs.push_back(mk(1'b1, 32'h0000_0010, 32'h0123_4567, 4'hF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0123_4567, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1));
        vecs.push_back(mk(1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0021, 32'h0,         4'h0, 32'h0,         1'b1));
        vecs.push_back(mk(1'b1, 32'h0000_0400, 32'h1234_5678, 4'hF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1234_5678, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0024, 32'h1122_3344, 4'hF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0024, 32'hAABB_CCDD, 4'hA, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hAA22_CC44, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0));
        vecs.push_back(mk(1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'hCAFE_F00D, 1'b0));
        vecs.push_back(mk(1'b1, 32'h0000_0030, 32'h0BAD_F00D, 4'hF, 32'h0,         1'b0));

        reset     = 1'b1;
        rst1      = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        repeat (2) @(negedge clock);
        check("rst ready", req_ready, 1);
        check("rst resp_valid", resp_valid, 0);
        check("rst rdata", resp_rdata, 0);
        check("rst err", resp_err, 0);
        check("rst stall", mem_stall, 0);
`ifdef DMEM_MMIO_EN
        check("rst mmio", mmio_out, 0);
`endif
        reset = 1'b0;
        rst1  = 1'b0;
        @(negedge clock);
        check("idle stall", mem_stall, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i], 1'b1);
        end

`ifdef DMEM_MMIO_EN
        run_txn("mmio_st", mk(1'b1, 32'hFFFF_FF00, 32'h0000_0005, 4'hF, 32'h0, 1'b0), 1'b1);
        check("mmio_out", mmio_out, 32'h0000_0005);
        run_txn("mmio_ld0", mk(1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h1234_5678, 1'b0), 1'b1);
        run_txn("mmio_ld", mk(1'b0, 32'hFFFF_FF00, 32'h0, 4'h0, 32'h0000_0005, 1'b0), 1'b1);
`endif

        // Reset in the second BUSY cycle of a store must abort it.
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0030;
        req_wdata = 32'h9999_9999;
        req_be    = 4'hF;
        @(negedge clock);
        req_valid = 1'b0;
        check("abort busy1_ready", req_ready, 0);
        @(negedge clock);
        check("abort busy2_stall", mem_stall, 1);
        reset = 1'b1;
        #1;
        check("abort rst_ready", req_ready, 1);
        check("abort rst_valid", resp_valid, 0);
        check("abort rst_stall", mem_stall, 0);
        @(negedge clock);
        reset    = 1'b0;
        saw_resp = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if (resp_valid !== 1'b0) saw_resp = 1'b1;
        end
        check("abort no_resp", saw_resp, 0);
        run_txn("abort_ld", mk(1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", n_checks, 32'hFFFF_FFFF);
        $fatal(1, "bench timeout");
    end

endmodule
